fpu_muldiv_issue_ctrl: RTL and testbench
========================================

// Module: fpu_muldiv_issue_ctrl
// PURPOSE
//  Issue/writeback sequencer directly upstream of FPU_IEEE754_MulDiv_Unified.
//  Accepts one FP80 mul/div request (valid/ready), drives the unit's enable/operand
//  port, waits for done, then holds the result, flags and tag for the consumer.
//  Also keeps sticky exception flags for the FPU status word and a watchdog on done.
// PARAMETERS
//  TAG_W      3    width of request/response tag
//  TIMEOUT    255  max WAIT cycles before watchdog abort (1..2^TIMEOUT_W-1)
//  TIMEOUT_W  8    watchdog counter width
// PORTS
//  clk               in   1      clock, rising edge
//  reset_n           in   1      asynchronous, active-low reset
//  req_valid         in   1      request present
//  req_ready         out  1      controller idle, can accept
//  req_op            in   1      0=multiply, 1=divide
//  req_a, req_b      in   80     FP80 operands
//  req_rmode         in   2      rounding mode
//  req_tag           in   TAG_W  opaque tag, returned with response
//  mdu_enable        out  1      one-cycle start pulse to unit
//  mdu_operation     out  1      latched req_op
//  mdu_operand_a/b   out  80     latched operands, stable ISSUE..WAIT
//  mdu_rounding_mode out  2      latched req_rmode
//  mdu_result        in   80     unit result
//  mdu_done          in   1      unit done
//  mdu_flags         in   5      {invalid,div_by_zero,overflow,underflow,inexact}
//  rsp_valid         out  1      response held
//  rsp_ready         in   1      consumer takes response
//  rsp_result        out  80     captured result
//  rsp_flags         out  5      captured flags, same order as mdu_flags
//  rsp_tag           out  TAG_W  tag of this response
//  sticky_flags      out  5      OR of all rsp_flags since last clear
//  sticky_clear      in   1      synchronous clear of sticky_flags
//  timeout_err       out  1      sticky watchdog-abort indicator, cleared by sticky_clear
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; req_ready=1; all other outputs 0.
//   Reset mid-operation aborts at once; mdu_enable drops immediately; nothing replayed.
//  FSM: IDLE -> ISSUE -> GUARD -> WAIT -> RESP -> IDLE.
//   IDLE : req_ready=1. req_valid at edge -> latch op/a/b/rmode/tag, go ISSUE.
//   ISSUE: mdu_enable=1 for exactly this cycle; go GUARD.
//   GUARD: mdu_done ignored (stale done from previous op); clear watchdog; go WAIT.
//   WAIT : edge with mdu_done=1 -> capture mdu_result/mdu_flags, go RESP.
//          Watchdog +1 per WAIT cycle; reaching TIMEOUT without done -> result
//          7FFF_C000_0000_0000_0000, flags=5'b10000, set timeout_err, go RESP.
//          done on the same edge the count reaches TIMEOUT: done wins, no abort.
//   RESP : rsp_valid=1, rsp_* stable until rsp_ready=1 at edge -> IDLE.
//  req_ready=0 outside IDLE; no request accepted in the RESP->IDLE cycle.
//  Min latency: accept edge E0; enable high E0..E1; done seen earliest at E3;
//   rsp_valid high after E3 (unit latency dominates).
//  Sticky: on WAIT->RESP edge sticky_flags |= captured flags. sticky_clear on the
//   same edge clears old bits, new captured flags still set.
//  mdu_operand_*/operation/rounding_mode: hold last latched value while IDLE.
// STRUCTURE
//  Package fpu_muldiv_pkg: state enum, FLAG_* bit indices, OP_MUL/OP_DIV,
//   FP80_QNAN constant (7FFF_C000_0000_0000_0000).
//  One sub-module: fpu_op_watchdog (load/count/expire, params TIMEOUT, TIMEOUT_W).
// TESTING (bench pairs with real FPU_IEEE754_MulDiv_Unified plus a stub unit)
//  1. req mul 4000_8000..0 x 4000_8000..0 tag=5 -> one mdu_enable pulse;
//     rsp_result=4001_8000_0000_0000_0000, rsp_flags=0, rsp_tag=5.
//  2. req div 3FFF_8000..0 / 0 -> rsp_result=7FFF_8000_0000_0000_0000,
//     rsp_flags[3]=1, sticky_flags=5'b01000. Then sticky_clear -> sticky_flags=0.
//  3. Stub never asserts done, TIMEOUT=16 -> rsp after 16 WAIT cycles,
//     result 7FFF_C000..0, flags=5'b10000, timeout_err=1.
//  4. rsp_ready low 10 cycles with req_valid high -> rsp_* stable, req_ready=0,
//     no second mdu_enable until after rsp handshake.
//  5. Stub holds done=1 from previous op -> GUARD ignores it; capture only the
//     fresh done; sticky_clear coincident with capture keeps new flags.
//  6. reset_n low during WAIT -> all outputs 0, req_ready=1; next request correct.

Source files
------------

// File: rtl/fpu_muldiv_pkg.sv
// rtl/fpu_muldiv_pkg.sv - shared types and constants for the FP80 mul/div issue controller
package fpu_muldiv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_GUARD = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RESP  = 3'd4
   } state_e;

   localparam int FLAG_INEXACT     = 0;
   localparam int FLAG_UNDERFLOW   = 1;
   localparam int FLAG_OVERFLOW    = 2;
   localparam int FLAG_DIV_BY_ZERO = 3;
   localparam int FLAG_INVALID     = 4;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   localparam logic [79:0] FP80_QNAN     = 80'h7FFF_C000_0000_0000_0000;
   localparam logic [4:0]  TIMEOUT_FLAGS = 5'(1 << FLAG_INVALID);

   // Clear drops the old bits first, so flags captured on the same edge survive.
   function automatic logic [4:0] merge_sticky(input logic [4:0] old_flags,
                                               input logic       clr,
                                               input logic [4:0] new_flags);
      return (clr ? 5'b0 : old_flags) | new_flags;
   endfunction

endpackage

// File: rtl/fpu_op_watchdog.sv
// rtl/fpu_op_watchdog.sv - cycle watchdog for an outstanding mul/div operation
module fpu_op_watchdog #(
   parameter int TIMEOUT   = 255,
   parameter int TIMEOUT_W = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic count,
   output logic expire
);

   localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT - 1);

   logic [TIMEOUT_W-1:0] count_q, count_d;

   // Expire fires on the count edge that would make the tally reach TIMEOUT.
   assign expire = count && (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = '0;
      end else if (count && !expire) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/fpu_muldiv_issue_ctrl.sv
// rtl/fpu_muldiv_issue_ctrl.sv - issue/writeback sequencer for the FP80 mul/div unit
module fpu_muldiv_issue_ctrl
   import fpu_muldiv_pkg::*;
#(
   parameter int TAG_W     = 3,
   parameter int TIMEOUT   = 255,
   parameter int TIMEOUT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_op,
   input  logic [79:0]      req_a,
   input  logic [79:0]      req_b,
   input  logic [1:0]       req_rmode,
   input  logic [TAG_W-1:0] req_tag,
   output logic             mdu_enable,
   output logic             mdu_operation,
   output logic [79:0]      mdu_operand_a,
   output logic [79:0]      mdu_operand_b,
   output logic [1:0]       mdu_rounding_mode,
   input  logic [79:0]      mdu_result,
   input  logic             mdu_done,
   input  logic [4:0]       mdu_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [79:0]      rsp_result,
   output logic [4:0]       rsp_flags,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [4:0]       sticky_flags,
   input  logic             sticky_clear,
   output logic             timeout_err
);

   state_e             state_q, state_d;
   logic               req_ready_q, req_ready_d;
   logic               mdu_enable_q, mdu_enable_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               op_q, op_d;
   logic [79:0]        opa_q, opa_d;
   logic [79:0]        opb_q, opb_d;
   logic [1:0]         rmode_q, rmode_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [79:0]        rsp_result_q, rsp_result_d;
   logic [4:0]         rsp_flags_q, rsp_flags_d;
   logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
   logic [4:0]         sticky_q, sticky_d;
   logic               timeout_err_q, timeout_err_d;
   logic               wd_load, wd_count, wd_expire;

   fpu_op_watchdog #(
      .TIMEOUT   (TIMEOUT),
      .TIMEOUT_W (TIMEOUT_W)
   ) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (wd_load),
      .count   (wd_count),
      .expire  (wd_expire)
   );

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      opa_d         = opa_q;
      opb_d         = opb_q;
      rmode_d       = rmode_q;
      tag_d         = tag_q;
      rsp_result_d  = rsp_result_q;
      rsp_flags_d   = rsp_flags_q;
      rsp_tag_d     = rsp_tag_q;
      sticky_d      = merge_sticky(sticky_q, sticky_clear, 5'b0);
      timeout_err_d = timeout_err_q && !sticky_clear;
      wd_load       = 1'b0;
      wd_count      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               opa_d   = req_a;
               opb_d   = req_b;
               rmode_d = req_rmode;
               tag_d   = req_tag;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_GUARD;
         end
         ST_GUARD: begin
            // A done still high from the previous operation is deliberately skipped here.
            wd_load = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            wd_count = 1'b1;
            if (mdu_done) begin
               rsp_result_d = mdu_result;
               rsp_flags_d  = mdu_flags;
               rsp_tag_d    = tag_q;
               sticky_d     = merge_sticky(sticky_q, sticky_clear, mdu_flags);
               state_d      = ST_RESP;
            end else if (wd_expire) begin
               rsp_result_d  = FP80_QNAN;
               rsp_flags_d   = TIMEOUT_FLAGS;
               rsp_tag_d     = tag_q;
               sticky_d      = merge_sticky(sticky_q, sticky_clear, TIMEOUT_FLAGS);
               timeout_err_d = 1'b1;
               state_d       = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      req_ready_d  = (state_d == ST_IDLE);
      mdu_enable_d = (state_d == ST_ISSUE);
      rsp_valid_d  = (state_d == ST_RESP);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         req_ready_q   <= 1'b1;
         mdu_enable_q  <= 1'b0;
         rsp_valid_q   <= 1'b0;
         op_q          <= 1'b0;
         opa_q         <= '0;
         opb_q         <= '0;
         rmode_q       <= '0;
         tag_q         <= '0;
         rsp_result_q  <= '0;
         rsp_flags_q   <= '0;
         rsp_tag_q     <= '0;
         sticky_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_ready_q   <= req_ready_d;
         mdu_enable_q  <= mdu_enable_d;
         rsp_valid_q   <= rsp_valid_d;
         op_q          <= op_d;
         opa_q         <= opa_d;
         opb_q         <= opb_d;
         rmode_q       <= rmode_d;
         tag_q         <= tag_d;
         rsp_result_q  <= rsp_result_d;
         rsp_flags_q   <= rsp_flags_d;
         rsp_tag_q     <= rsp_tag_d;
         sticky_q      <= sticky_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign req_ready         = req_ready_q;
   assign mdu_enable        = mdu_enable_q;
   assign mdu_operation     = op_q;
   assign mdu_operand_a     = opa_q;
   assign mdu_operand_b     = opb_q;
   assign mdu_rounding_mode = rmode_q;
   assign rsp_valid         = rsp_valid_q;
   assign rsp_result        = rsp_result_q;
   assign rsp_flags         = rsp_flags_q;
   assign rsp_tag           = rsp_tag_q;
   assign sticky_flags      = sticky_q;
   assign timeout_err       = timeout_err_q;

endmodule

// File: tb/tb_fpu_muldiv_issue_ctrl.sv
// tb/tb_fpu_muldiv_issue_ctrl.sv - self-checking bench with stub unit and transaction model
module tb_fpu_muldiv_issue_ctrl;

   localparam int TAG_W = 3;
   localparam int TMO   = 16;
   localparam int TW    = 8;
   localparam logic [79:0] QNAN = 80'h7FFF_C000_0000_0000_0000;
   localparam logic [79:0] TWO  = 80'h4000_8000_0000_0000_0000;
   localparam logic [79:0] ONE  = 80'h3FFF_8000_0000_0000_0000;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic req_valid = 1'b0, req_op = 1'b0;
   logic [79:0] req_a = '0, req_b = '0;
   logic [1:0] req_rmode = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic req_ready, mdu_enable, mdu_operation;
   logic [79:0] mdu_operand_a, mdu_operand_b;
   logic [1:0] mdu_rounding_mode;
   logic [79:0] mdu_result = '0;
   logic mdu_done = 1'b0;
   logic [4:0] mdu_flags = '0;
   logic rsp_valid, rsp_ready = 1'b0;
   logic [79:0] rsp_result;
   logic [4:0] rsp_flags;
   logic [TAG_W-1:0] rsp_tag;
   logic [4:0] sticky_flags;
   logic sticky_clear = 1'b0;
   logic timeout_err;

   always #5 clk = ~clk;

   fpu_muldiv_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TMO), .TIMEOUT_W(TW)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_rmode(req_rmode), .req_tag(req_tag),
      .mdu_enable(mdu_enable), .mdu_operation(mdu_operation),
      .mdu_operand_a(mdu_operand_a), .mdu_operand_b(mdu_operand_b),
      .mdu_rounding_mode(mdu_rounding_mode), .mdu_result(mdu_result),
      .mdu_done(mdu_done), .mdu_flags(mdu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
      .sticky_flags(sticky_flags), .sticky_clear(sticky_clear), .timeout_err(timeout_err)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behaviour of the stand-in arithmetic unit: {flags, result}.
   function automatic logic [84:0] stub_fn(input logic op, input logic [79:0] a,
                                           input logic [79:0] b, input logic [1:0] rm);
      logic [79:0] r;
      logic [4:0]  f;
      if (!op && a == TWO && b == TWO) return {5'b00000, 80'h4001_8000_0000_0000_0000};
      if (op && a == ONE && b == 80'h0) return {5'b01000, 80'h7FFF_8000_0000_0000_0000};
      r = {a[39:0] ^ b[79:40], a[79:40] + b[39:0]} ^ {op, 77'b0, rm};
      f = a[4:0] ^ b[9:5] ^ {op, 2'b00, rm};
      return {f, r};
   endfunction

   // Stub unit: lat = negedges after seeing enable until done (0 = never); hold keeps done high.
   int  stub_lat = 2;
   bit  stub_hold = 1'b0;
   int  sk = -1, cur_lat = 2;
   bit  cur_hold = 1'b0;
   logic [84:0] pend = '0;

   always @(negedge clk) begin
      if (!reset_n) begin
         mdu_done = 1'b0; mdu_result = '0; mdu_flags = '0; sk = -1;
      end else if (mdu_enable) begin
         sk = 0; cur_lat = stub_lat; cur_hold = stub_hold;
         pend = stub_fn(mdu_operation, mdu_operand_a, mdu_operand_b, mdu_rounding_mode);
         if (!cur_hold) mdu_done = 1'b0;
      end else if (sk >= 0) begin
         sk++;
         if (cur_lat != 0 && sk == cur_lat) begin
            mdu_done = 1'b1;
            {mdu_flags, mdu_result} = pend;
         end else if (sk == 2 || !cur_hold) begin
            mdu_done = 1'b0;
         end
      end
   end

   // Transaction model: one outstanding op, response edge = accept + 2 + wait edges.
   bit busy = 1'b0, e_timed = 1'b0, e_terr = 1'b0;
   int cyc = 0, t_acc = 0, resp_edge = 0;
   logic e_op = 1'b0;
   logic [79:0] e_a = '0, e_b = '0, e_res = '0;
   logic [1:0] e_rm = '0;
   logic [4:0] e_flags = '0, e_sticky = '0;
   logic [TAG_W-1:0] e_tag = '0;

   always @(posedge clk) begin
      bit was;
      int w;
      cyc++;
      if (reset_n) begin
         was = busy;
         if (sticky_clear) begin e_sticky = '0; e_terr = 1'b0; end
         if (was && cyc == resp_edge) begin e_sticky |= e_flags; e_terr |= e_timed; end
         if (!was && req_valid) begin
            busy = 1'b1; t_acc = cyc;
            e_op = req_op; e_a = req_a; e_b = req_b; e_rm = req_rmode; e_tag = req_tag;
            if (stub_lat == 0 || stub_lat - 1 > TMO) begin
               w = TMO; e_timed = 1'b1; e_res = QNAN; e_flags = 5'b10000;
            end else begin
               w = stub_lat - 1; e_timed = 1'b0;
               {e_flags, e_res} = stub_fn(req_op, req_a, req_b, req_rmode);
            end
            resp_edge = cyc + 2 + w;
         end else if (was && cyc > resp_edge && rsp_ready) begin
            busy = 1'b0;
         end
      end
   end

   always @(negedge reset_n) begin
      busy = 1'b0; e_sticky = '0; e_terr = 1'b0;
      e_op = 1'b0; e_a = '0; e_b = '0; e_rm = '0;
   end

   always @(negedge clk) begin
      chk("req_ready", 80'(req_ready), 80'(!busy));
      chk("mdu_enable", 80'(mdu_enable), 80'(busy && cyc == t_acc));
      chk("rsp_valid", 80'(rsp_valid), 80'(busy && cyc >= resp_edge));
      if (busy && cyc >= resp_edge) begin
         chk("rsp_result", rsp_result, e_res);
         chk("rsp_flags", 80'(rsp_flags), 80'(e_flags));
         chk("rsp_tag", 80'(rsp_tag), 80'(e_tag));
      end
      chk("sticky_flags", 80'(sticky_flags), 80'(e_sticky));
      chk("timeout_err", 80'(timeout_err), 80'(e_terr));
      chk("mdu_operation", 80'(mdu_operation), 80'(e_op));
      chk("mdu_operand_a", mdu_operand_a, e_a);
      chk("mdu_operand_b", mdu_operand_b, e_b);
      chk("mdu_rounding_mode", 80'(mdu_rounding_mode), 80'(e_rm));
   end

   int en_cnt = 0;
   always @(negedge clk) if (mdu_enable) en_cnt++;

   bit rand_clr = 1'b0;
   always @(negedge clk) if (rand_clr) sticky_clear = ($urandom_range(0, 7) == 0);

   logic [79:0] got_res;
   logic [4:0]  got_flags;
   logic [TAG_W-1:0] got_tag;
   int got_n;

   task automatic do_req(input logic op, input logic [79:0] a, input logic [79:0] b,
                         input logic [1:0] rm, input logic [TAG_W-1:0] tag, input int lat,
                         input bit hold, input int rdy_dly, input bit keep_valid,
                         input bit clr_at_resp);
      int n;
      stub_lat = lat; stub_hold = hold;
      req_op = op; req_a = a; req_b = b; req_rmode = rm; req_tag = tag; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      if (!req_ready) begin
         errors++; checks++;
         $display("FAIL accept_wait: req_ready stayed 0 for %0d cycles, required 1", n);
      end
      @(negedge clk);
      req_valid = keep_valid;
      n = 0;
      while (!rsp_valid && n < TMO + 10) begin
         if (clr_at_resp) sticky_clear = (n == lat);
         @(negedge clk); n++;
      end
      if (clr_at_resp) sticky_clear = 1'b0;
      got_n = n; got_res = rsp_result; got_flags = rsp_flags; got_tag = rsp_tag;
      if (!rsp_valid) begin
         errors++; checks++;
         $display("FAIL rsp_wait: rsp_valid stayed 0 for %0d cycles, required 1", n);
      end
      repeat (rdy_dly) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0; req_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation time limit reached, required completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      int e0;
      logic [84:0] fr;
      logic [79:0] ra, rb;
      int l;

      repeat (2) @(negedge clk);
      chk("reset_req_ready", 80'(req_ready), 80'(1));
      chk("reset_mdu_enable", 80'(mdu_enable), 80'(0));
      chk("reset_rsp_valid", 80'(rsp_valid), 80'(0));
      chk("reset_rsp_result", rsp_result, 80'h0);
      chk("reset_sticky", 80'(sticky_flags), 80'(0));
      reset_n = 1'b1;
      @(negedge clk);

      e0 = en_cnt;
      do_req(1'b0, TWO, TWO, 2'd0, 3'd5, 2, 1'b0, 0, 1'b0, 1'b0);
      chk("t1_result", got_res, 80'h4001_8000_0000_0000_0000);
      chk("t1_flags", 80'(got_flags), 80'(0));
      chk("t1_tag", 80'(got_tag), 80'(5));
      chk("t1_enable_pulses", 80'(en_cnt - e0), 80'(1));
      chk("t1_min_latency", 80'(got_n), 80'(3));

      do_req(1'b1, ONE, 80'h0, 2'd0, 3'd2, 5, 1'b0, 1, 1'b0, 1'b0);
      chk("t2_result", got_res, 80'h7FFF_8000_0000_0000_0000);
      chk("t2_flag_dz", 80'(got_flags[3]), 80'(1));
      chk("t2_sticky", 80'(sticky_flags), 80'(5'b01000));
      sticky_clear = 1'b1; @(negedge clk); sticky_clear = 1'b0;
      chk("t2_sticky_cleared", 80'(sticky_flags), 80'(0));

      do_req(1'b0, TWO, ONE, 2'd1, 3'd3, 0, 1'b0, 0, 1'b0, 1'b0);
      chk("t3_result", got_res, QNAN);
      chk("t3_flags", 80'(got_flags), 80'(5'b10000));
      chk("t3_timeout_err", 80'(timeout_err), 80'(1));
      chk("t3_latency", 80'(got_n), 80'(2 + TMO));
      sticky_clear = 1'b1; @(negedge clk); sticky_clear = 1'b0;
      chk("t3_terr_cleared", 80'(timeout_err), 80'(0));

      ra = 80'h1234_5678_9ABC_DEF0_1357; rb = 80'h0F0F_1111_2222_3333_4444;
      fr = stub_fn(1'b1, ra, rb, 2'd2);
      do_req(1'b1, ra, rb, 2'd2, 3'd6, TMO + 1, 1'b0, 0, 1'b0, 1'b0);
      chk("edge_done_wins_result", got_res, fr[79:0]);
      chk("edge_done_wins_terr", 80'(timeout_err), 80'(0));
      do_req(1'b1, ra, rb, 2'd2, 3'd6, TMO + 2, 1'b0, 0, 1'b0, 1'b0);
      chk("edge_abort_result", got_res, QNAN);
      sticky_clear = 1'b1; @(negedge clk); sticky_clear = 1'b0;

      e0 = en_cnt;
      do_req(1'b0, rb, ra, 2'd3, 3'd1, 3, 1'b0, 10, 1'b1, 1'b0);
      chk("t4_enable_pulses", 80'(en_cnt - e0), 80'(1));

      do_req(1'b0, ra, ra, 2'd1, 3'd4, 3, 1'b1, 0, 1'b0, 1'b0);
      fr = stub_fn(1'b1, rb, ra, 2'd0);
      do_req(1'b1, rb, ra, 2'd0, 3'd7, 4, 1'b1, 0, 1'b0, 1'b1);
      chk("t5_fresh_result", got_res, fr[79:0]);
      chk("t5_sticky_new_only", 80'(sticky_flags), 80'(fr[84:80]));

      stub_lat = 0; stub_hold = 1'b0;
      req_op = 1'b1; req_a = ra; req_b = rb; req_rmode = 2'd2; req_tag = 3'd3; req_valid = 1'b1;
      while (!req_ready) @(negedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("t6_req_ready", 80'(req_ready), 80'(1));
      chk("t6_mdu_enable", 80'(mdu_enable), 80'(0));
      chk("t6_rsp_valid", 80'(rsp_valid), 80'(0));
      chk("t6_operand_a", mdu_operand_a, 80'h0);
      chk("t6_rsp_tag", 80'(rsp_tag), 80'(0));
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      do_req(1'b0, TWO, TWO, 2'd0, 3'd6, 2, 1'b0, 0, 1'b0, 1'b0);
      chk("t6_after_result", got_res, 80'h4001_8000_0000_0000_0000);
      chk("t6_after_tag", 80'(got_tag), 80'(6));

      rand_clr = 1'b1;
      for (int i = 0; i < 150; i++) begin
         ra = {$urandom(), $urandom(), 16'($urandom())};
         rb = {$urandom(), $urandom(), 16'($urandom())};
         l = $urandom_range(0, TMO + 3);
         if (l == 1) l = 2;
         do_req(1'($urandom_range(0, 1)), ra, rb, 2'($urandom_range(0, 3)),
                TAG_W'($urandom_range(0, 7)), l, 1'($urandom_range(0, 1)),
                $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0);
      end
      rand_clr = 1'b0;
      sticky_clear = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
